prog_load_dump_ctrl: RTL and testbench
======================================

Name: prog_load_dump_ctrl

Overview:
Parametrised on-chip bring-up controller that replaces the bench-driven byte loading and result readout around the CPU. A byte stream on in_byte holds a start token, a word count and the program bytes. The block assembles the bytes into instruction words and writes them to instruction memory. It then lets the CPU run for a fixed cycle budget, reads DUMP_WORDS words back from the data-memory debug port, and streams them out byte-wise with a valid/ready handshake. It sits between the pad-level byte interface and the CPU top.

Parameters:
BYTE_W, 8, width of one stream byte
WORD_BYTES, 4, bytes per instruction/data word; WORD_W = BYTE_W*WORD_BYTES
IMEM_DEPTH, 64, instruction memory depth in words; IAW = clog2(IMEM_DEPTH)
DUMP_WORDS, 16, number of data words read back; DAW = clog2(DUMP_WORDS)
RUN_CYCLES, 200, cycles the CPU is enabled
START_TOKEN, 8'hFE, byte that opens a load session

Ports:
clk_i  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  in_byte qualifier
in_byte  in  BYTE_W  stream byte
imem_we  out  1  instruction memory write strobe
imem_addr  out  IAW  instruction memory word address
imem_wdata  out  WORD_W  assembled instruction word
cpu_reset_o  out  1  holds CPU in reset
cpu_run_o  out  1  CPU enable
dump_rd  out  1  data-memory read strobe
dump_addr  out  DAW  data-memory word address
dump_rdata  in  WORD_W  read data, valid 1 cycle after dump_rd
dout_valid  out  1  output byte valid
dout_byte  out  BYTE_W  output byte
dout_ready  in  1  sink accepts byte
busy  out  1  state not IDLE/DONE/ERR
done  out  1  session complete
err  out  1  bad word count

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on port reset.
- All outputs are registered.
- While reset is asserted: state=IDLE, cpu_reset_o=1, all other outputs 0, all counters cleared. Memory contents are untouched. A reset mid-session aborts the session immediately on the next edge.
- States: IDLE, LEN, LOAD, WFLUSH, RUN, DRD, DWAIT, DTX, DONE, ERR.
- IDLE:
  - in_valid && in_byte==START_TOKEN -> LEN.
  - Any other byte is ignored.
- LEN:
  - The next valid byte is the word count N.
  - N==0 or N>IMEM_DEPTH -> ERR.
  - Otherwise latch N, clear word_idx and byte_idx, -> LOAD.
- LOAD:
  - Each valid byte is shifted into the accumulator, MSB first.
  - Cycles without in_valid hold all state; there is no timeout.
  - In LOAD, a byte equal to START_TOKEN is treated as data.
- Word write: on the edge that accepts byte WORD_BYTES-1, the next cycle has imem_we=1 (single-cycle pulse), imem_addr=word_idx and imem_wdata=the assembled word; word_idx then increments.
- Last word: after the last byte of word N-1, the state goes to WFLUSH (that cycle carries the imem_we pulse), then -> RUN.
- RUN:
  - cpu_reset_o=0 and cpu_run_o=1 from the first RUN cycle.
  - Lasts exactly RUN_CYCLES cycles, then -> DRD with cpu_run_o=0.
  - cpu_reset_o stays 0 so CPU state is preserved for the dump.
- Input during RUN, DRD, DWAIT and DTX is ignored.
- Dump read: DRD drives dump_rd=1 for one cycle with dump_addr=k. DWAIT captures dump_rdata into the shift register and sets byte_cnt=0. Then -> DTX.
- DTX:
  - dout_valid=1 and dout_byte=shift register MSB byte.
  - dout_byte is held stable while dout_valid && !dout_ready.
  - On each valid&&ready edge, shift left by BYTE_W. After WORD_BYTES accepted bytes, k increments; if k < DUMP_WORDS -> DRD, else -> DONE.
  - dout_valid drops in the cycle after the final acceptance.
- DONE:
  - done=1 and cpu_reset_o=0, held.
  - A START_TOKEN -> LEN, clearing done and reasserting cpu_reset_o.
- ERR:
  - err=1 and cpu_reset_o=1.
  - Sticky until reset; all input is ignored.
- Minimum latency from START_TOKEN to the first dout_valid (input gapless, dout_ready=1): 1 + N*WORD_BYTES + 1 + RUN_CYCLES + 2 cycles.

Test Plan:
1. Reset, then stream FE,02,00,00,00,13,00,50,00,93 gaplessly -> imem_we pulses twice, with (addr0, 0x00000013) and (addr1, 0x00500093); cpu_reset_o falls on the cycle after the second pulse; cpu_run_o is high for exactly 200 cycles.
2. Dump with dump_rdata = 0xA0A1A2A3 + k*0x04040404 and dout_ready=1 -> 64 bytes in the order A0,A1,A2,A3,A4,…; done=1 after byte 63; dout_valid is never high in RUN.
3. Toggle dout_ready randomly during DTX -> dout_byte is stable across every stalled cycle; no byte is lost or duplicated; the byte count is exactly 64.
4. FE,00 -> err=1 and cpu_reset_o stays 1; FE,41 (N=65 > 64) -> err; subsequent FE bytes are ignored until reset.
5. in_valid gaps of 3 cycles between bytes, plus an FE inside the payload -> same imem writes as the gapless case, with FE stored as data.
6. Assert reset during RUN at cycle 50 -> next edge is IDLE with cpu_reset_o=1 and cpu_run_o=0. Then do a fresh load from DONE with FE -> a second session completes.

Source files
------------

// File: rtl/prog_load_dump_ctrl.sv
// Bring-up controller: loads a byte-streamed program into instruction memory,
// runs the CPU for a fixed cycle budget, then streams a data-memory dump out
// byte-wise with a valid/ready handshake.
//
// Ports:
//   clk_i, reset          clock, synchronous active-high reset
//   in_valid, in_byte     input byte stream (start token, word count, payload)
//   imem_we/addr/wdata    instruction memory write port
//   cpu_reset_o           holds the CPU in reset
//   cpu_run_o             CPU enable, high for RUN_CYCLES cycles
//   dump_rd/addr/rdata    data-memory debug read port (1-cycle read latency)
//   dout_valid/byte/ready output byte stream
//   busy, done, err       session status
module prog_load_dump_ctrl #(
   parameter int unsigned BYTE_W      = 8,
   parameter int unsigned WORD_BYTES  = 4,
   parameter int unsigned IMEM_DEPTH  = 64,
   parameter int unsigned DUMP_WORDS  = 16,
   parameter int unsigned RUN_CYCLES  = 200,
   parameter logic [BYTE_W-1:0] START_TOKEN = BYTE_W'(8'hFE),
   localparam int unsigned WORD_W = BYTE_W * WORD_BYTES,
   localparam int unsigned IAW    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
   localparam int unsigned DAW    = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              imem_we,
   output logic [IAW-1:0]    imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_reset_o,
   output logic              cpu_run_o,
   output logic              dump_rd,
   output logic [DAW-1:0]    dump_addr,
   input  logic [WORD_W-1:0] dump_rdata,
   output logic              dout_valid,
   output logic [BYTE_W-1:0] dout_byte,
   input  logic              dout_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned NW  = IAW + 1;
   localparam int unsigned KW  = DAW + 1;
   localparam int unsigned BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int unsigned RCW = $clog2(RUN_CYCLES + 1);

   typedef enum logic [3:0] {
      IDLE, LEN, LOAD, WFLUSH, RUN, DRD, DWAIT, DTX, DONE, ERR
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [BIW-1:0]    byte_idx_q, byte_idx_d;
   logic [NW-1:0]     word_idx_q, word_idx_d;
   logic [NW-1:0]     n_words_q, n_words_d;
   logic [RCW-1:0]    run_cnt_q, run_cnt_d;
   logic [KW-1:0]     k_q, k_d;
   logic [BIW-1:0]    bcnt_q, bcnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic              we_d;
   logic [IAW-1:0]    waddr_d;
   logic [WORD_W-1:0] wdata_d;

   // Next-state and datapath next values
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      n_words_d  = n_words_q;
      run_cnt_d  = run_cnt_q;
      k_d        = k_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      we_d       = 1'b0;
      waddr_d    = imem_addr;
      wdata_d    = imem_wdata;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_byte == START_TOKEN) state_d = LEN;
         end
         LEN: begin
            if (in_valid) begin
               if (in_byte == '0 || 32'(in_byte) > 32'(IMEM_DEPTH)) begin
                  state_d = ERR;
               end else begin
                  n_words_d  = NW'(in_byte);
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  state_d    = LOAD;
               end
            end
         end
         LOAD: begin
            // Start tokens are plain data here; bytes enter MSB first
            if (in_valid) begin
               acc_d = (acc_q << BYTE_W) | WORD_W'(in_byte);
               if (byte_idx_q == BIW'(WORD_BYTES - 1)) begin
                  byte_idx_d = '0;
                  we_d       = 1'b1;
                  waddr_d    = IAW'(word_idx_q);
                  wdata_d    = acc_d;
                  word_idx_d = word_idx_q + NW'(1);
                  if (word_idx_q == n_words_q - NW'(1)) state_d = WFLUSH;
               end else begin
                  byte_idx_d = byte_idx_q + BIW'(1);
               end
            end
         end
         WFLUSH: begin
            run_cnt_d = '0;
            k_d       = '0;
            state_d   = RUN;
         end
         RUN: begin
            if (run_cnt_q == RCW'(RUN_CYCLES - 1)) state_d = DRD;
            else run_cnt_d = run_cnt_q + RCW'(1);
         end
         DRD: begin
            state_d = DWAIT;
         end
         DWAIT: begin
            shift_d = dump_rdata;
            bcnt_d  = '0;
            state_d = DTX;
         end
         DTX: begin
            if (dout_valid && dout_ready) begin
               shift_d = shift_q << BYTE_W;
               if (bcnt_q == BIW'(WORD_BYTES - 1)) begin
                  bcnt_d  = '0;
                  k_d     = k_q + KW'(1);
                  state_d = (k_d < KW'(DUMP_WORDS)) ? DRD : DONE;
               end else begin
                  bcnt_d = bcnt_q + BIW'(1);
               end
            end
         end
         DONE: begin
            if (in_valid && in_byte == START_TOKEN) state_d = LEN;
         end
         ERR: begin
            state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         byte_idx_q  <= '0;
         word_idx_q  <= '0;
         n_words_q   <= '0;
         run_cnt_q   <= '0;
         k_q         <= '0;
         bcnt_q      <= '0;
         shift_q     <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         cpu_reset_o <= 1'b1;
         cpu_run_o   <= 1'b0;
         dump_rd     <= 1'b0;
         dump_addr   <= '0;
         dout_valid  <= 1'b0;
         dout_byte   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         byte_idx_q  <= byte_idx_d;
         word_idx_q  <= word_idx_d;
         n_words_q   <= n_words_d;
         run_cnt_q   <= run_cnt_d;
         k_q         <= k_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         imem_we     <= we_d;
         imem_addr   <= waddr_d;
         imem_wdata  <= wdata_d;
         // CPU stays out of reset after the run so its state survives the dump
         cpu_reset_o <= !(state_d inside {RUN, DRD, DWAIT, DTX, DONE});
         cpu_run_o   <= (state_d == RUN);
         dump_rd     <= (state_d == DRD);
         dump_addr   <= DAW'(k_d);
         dout_valid  <= (state_d == DTX);
         dout_byte   <= (state_d == DTX) ? shift_d[WORD_W-1 -: BYTE_W] : '0;
         busy        <= !(state_d inside {IDLE, DONE, ERR});
         done        <= (state_d == DONE);
         err         <= (state_d == ERR);
      end
   end

endmodule

// File: tb/tb_prog_load_dump_ctrl.sv
// Directed bench for prog_load_dump_ctrl: program load, run budget, dump
// stream with and without backpressure, error paths, input gaps and reset abort.
module tb_prog_load_dump_ctrl;

   logic        clk_i = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = '0;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset_o, cpu_run_o;
   logic        dump_rd;
   logic [3:0]  dump_addr;
   logic [31:0] dump_rdata = '0;
   logic        dout_valid;
   logic [7:0]  dout_byte;
   logic        dout_ready = 1'b1;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;
   bit rnd_ready = 1'b0;

   // Observation records, written only by the monitor
   logic [5:0]  wq_addr [$];
   logic [31:0] wq_data [$];
   logic [7:0]  dq [$];
   int cyc = 0, run_n = 0, vrun_n = 0, stall_viol = 0;
   int last_we_cyc = -1, fall_cyc = -1;
   logic prev_rst = 1'b1, stalled = 1'b0;
   logic [7:0] stall_byte = '0;

   // Bases captured by test_load for test_dump
   int s_db = 0, s_vb = 0;

   prog_load_dump_ctrl dut (
      .clk_i(clk_i), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_reset_o(cpu_reset_o), .cpu_run_o(cpu_run_o),
      .dump_rd(dump_rd), .dump_addr(dump_addr), .dump_rdata(dump_rdata),
      .dout_valid(dout_valid), .dout_byte(dout_byte), .dout_ready(dout_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk_i = ~clk_i;

   // Data memory: word k reads as A0A1A2A3 + k*04040404, one cycle latency
   always @(posedge clk_i)
      if (dump_rd) dump_rdata <= 32'hA0A1A2A3 + 32'(dump_addr) * 32'h04040404;

   always @(negedge clk_i) begin
      cyc++;
      if (imem_we) begin
         wq_addr.push_back(imem_addr);
         wq_data.push_back(imem_wdata);
         last_we_cyc = cyc;
      end
      if (cpu_run_o) run_n++;
      if (prev_rst && !cpu_reset_o) fall_cyc = cyc;
      prev_rst = cpu_reset_o;
      if (dout_valid && cpu_run_o) vrun_n++;
      if (stalled && !(dout_valid && dout_byte == stall_byte)) stall_viol++;
      stalled    = dout_valid && !dout_ready;
      stall_byte = dout_byte;
      if (dout_valid && dout_ready) dq.push_back(dout_byte);
   end

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; dout_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_valid = 1'b1; in_byte = b;
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   // FE, 02, then two words; fe_payload places an FE inside the first word
   task automatic send_prog(input int gap, input bit fe_payload, input bit with_token);
      logic [7:0] p [8];
      p = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93};
      if (fe_payload) p[1] = 8'hFE;
      if (with_token) send_byte(8'hFE, gap);
      send_byte(8'h02, gap);
      for (int i = 0; i < 8; i++) send_byte(p[i], gap);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 3000) begin
         dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      dout_ready = 1'b1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: done=%b after %0d cycles, required 1", tag, done, n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({cpu_reset_o, cpu_run_o, imem_we, dump_rd, dout_valid, busy, done, err} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 10000000",
                  {cpu_reset_o, cpu_run_o, imem_we, dump_rd, dout_valid, busy, done, err});
      end
   endtask

   task automatic test_load();
      int wb, rb;
      do_reset();
      wb = wq_addr.size(); rb = run_n; s_db = dq.size(); s_vb = vrun_n;
      send_prog(0, 1'b0, 1'b1);
      wait_done("load");
      checks++;
      if (wq_addr.size() - wb !== 2) begin
         errors++; $display("FAIL load_wcount: got %0d, required 2", wq_addr.size() - wb);
      end else begin
         checks++;
         if (wq_addr[wb] !== 6'd0 || wq_data[wb] !== 32'h00000013) begin
            errors++; $display("FAIL load_w0: got %0d/%h, required 0/00000013", wq_addr[wb], wq_data[wb]);
         end
         checks++;
         if (wq_addr[wb+1] !== 6'd1 || wq_data[wb+1] !== 32'h00500093) begin
            errors++; $display("FAIL load_w1: got %0d/%h, required 1/00500093", wq_addr[wb+1], wq_data[wb+1]);
         end
      end
      checks++;
      if (run_n - rb !== 200) begin
         errors++; $display("FAIL run_cycles: got %0d, required 200", run_n - rb);
      end
      checks++;
      if (fall_cyc !== last_we_cyc + 1) begin
         errors++; $display("FAIL reset_fall: got cycle %0d, required %0d", fall_cyc, last_we_cyc + 1);
      end
   endtask

   task automatic test_dump();
      checks++;
      if (dq.size() - s_db !== 64) begin
         errors++; $display("FAIL dump_count: got %0d, required 64", dq.size() - s_db);
      end else begin
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (dq[s_db+i] !== 8'(32'hA0 + i)) begin
               errors++; $display("FAIL dump_byte%0d: got %h, required %h", i, dq[s_db+i], 8'(32'hA0 + i));
            end
         end
      end
      checks++;
      if (vrun_n - s_vb !== 0) begin
         errors++; $display("FAIL valid_in_run: got %0d cycles, required 0", vrun_n - s_vb);
      end
      checks++;
      if ({done, dout_valid, busy, cpu_reset_o} !== 4'b1000) begin
         errors++; $display("FAIL done_state: got %b, required 1000", {done, dout_valid, busy, cpu_reset_o});
      end
   endtask

   task automatic test_backpressure();
      int db, sb;
      do_reset();
      db = dq.size(); sb = stall_viol;
      rnd_ready = 1'b1;
      send_prog(0, 1'b0, 1'b1);
      wait_done("bp");
      rnd_ready = 1'b0;
      checks++;
      if (dq.size() - db !== 64) begin
         errors++; $display("FAIL bp_count: got %0d, required 64", dq.size() - db);
      end else begin
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (dq[db+i] !== 8'(32'hA0 + i)) begin
               errors++; $display("FAIL bp_byte%0d: got %h, required %h", i, dq[db+i], 8'(32'hA0 + i));
            end
         end
      end
      checks++;
      if (stall_viol - sb !== 0) begin
         errors++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_viol - sb);
      end
   endtask

   task automatic test_err();
      int wb;
      do_reset();
      send_byte(8'hFE, 0); send_byte(8'h00, 0);
      checks++;
      if ({err, cpu_reset_o, busy} !== 3'b110) begin
         errors++; $display("FAIL err_zero: got %b, required 110", {err, cpu_reset_o, busy});
      end
      wb = wq_addr.size();
      send_prog(0, 1'b0, 1'b1);
      repeat (5) tick();
      checks++;
      if ({err, cpu_reset_o, busy, cpu_run_o} !== 4'b1100 || wq_addr.size() !== wb) begin
         errors++; $display("FAIL err_sticky: got %b writes %0d, required 1100 writes 0",
                            {err, cpu_reset_o, busy, cpu_run_o}, wq_addr.size() - wb);
      end
      do_reset();
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got %b, required 0", err);
      end
      send_byte(8'hFE, 0); send_byte(8'h41, 0);
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_65: got %b, required 1", err);
      end
      do_reset();
      send_byte(8'hFE, 0); send_byte(8'h40, 0);
      checks++;
      if ({err, busy} !== 2'b01) begin
         errors++; $display("FAIL len_64: got %b, required 01", {err, busy});
      end
   endtask

   task automatic test_gaps();
      int wb, rb;
      do_reset();
      wb = wq_addr.size(); rb = run_n;
      send_prog(3, 1'b1, 1'b1);
      wait_done("gaps");
      checks++;
      if (wq_addr.size() - wb !== 2) begin
         errors++; $display("FAIL gaps_wcount: got %0d, required 2", wq_addr.size() - wb);
      end else begin
         checks++;
         if (wq_addr[wb] !== 6'd0 || wq_data[wb] !== 32'h00FE0013) begin
            errors++; $display("FAIL gaps_w0: got %0d/%h, required 0/00FE0013", wq_addr[wb], wq_data[wb]);
         end
         checks++;
         if (wq_addr[wb+1] !== 6'd1 || wq_data[wb+1] !== 32'h00500093) begin
            errors++; $display("FAIL gaps_w1: got %0d/%h, required 1/00500093", wq_addr[wb+1], wq_data[wb+1]);
         end
      end
      checks++;
      if (run_n - rb !== 200) begin
         errors++; $display("FAIL gaps_run: got %0d, required 200", run_n - rb);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0, db, wb;
      do_reset();
      send_prog(0, 1'b0, 1'b1);
      while (cpu_run_o !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (cpu_run_o !== 1'b1) begin
         errors++; $display("FAIL abort_run_start: cpu_run_o=%b, required 1", cpu_run_o);
      end
      repeat (49) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({cpu_reset_o, cpu_run_o, busy} !== 3'b100) begin
         errors++; $display("FAIL abort_state: got %b, required 100", {cpu_reset_o, cpu_run_o, busy});
      end
      send_prog(0, 1'b0, 1'b1);
      wait_done("s1");
      db = dq.size(); wb = wq_addr.size();
      send_byte(8'hFE, 0);
      checks++;
      if ({done, cpu_reset_o, busy} !== 3'b011) begin
         errors++; $display("FAIL restart: got %b, required 011", {done, cpu_reset_o, busy});
      end
      send_prog(0, 1'b1, 1'b0);
      wait_done("s2");
      checks++;
      if (dq.size() - db !== 64 || wq_addr.size() - wb !== 2) begin
         errors++; $display("FAIL s2_counts: got %0d bytes %0d writes, required 64 and 2",
                            dq.size() - db, wq_addr.size() - wb);
      end else begin
         checks++;
         if (wq_data[wb] !== 32'h00FE0013 || dq[db+63] !== 8'hDF) begin
            errors++; $display("FAIL s2_data: got %h/%h, required 00FE0013/df", wq_data[wb], dq[db+63]);
         end
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_load();
      test_dump();
      test_backpressure();
      test_err();
      test_gaps();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
